// File: rtl/alu.sv
// Registered ALU: sixteen operations on two unsigned WIDTH-bit operands.
// The result and the carry of A+B are captured on every rising clock edge,
// giving one cycle of latency and one operation per cycle. Reset is
// synchronous and active-low, and it clears both output registers.
module alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut
);

  // Operation encodings
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_ROL  = 4'b0110;
  localparam logic [3:0] OP_ROR  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_XNOR = 4'b1101;
  localparam logic [3:0] OP_GT   = 4'b1110;
  localparam logic [3:0] OP_EQ   = 4'b1111;

  logic [WIDTH:0]   sum_full;   // A+B with the carry bit kept
  logic [WIDTH-1:0] result;     // next value of ALU_Out
  logic [WIDTH-1:0] quotient;   // A/B, all-ones when B is zero

  // The carry always comes from the extended sum, whatever ALU_Sel says
  assign sum_full = {1'b0, A} + {1'b0, B};

  // Division by zero saturates to all-ones instead of being left undefined
  always_comb begin
    quotient = '1;
    if (B != '0) begin
      quotient = A / B;
    end
  end

  // Select the result of the requested operation
  always_comb begin
    result = '0;
    case (ALU_Sel)
      OP_ADD:  result = sum_full[WIDTH-1:0];
      OP_SUB:  result = A - B;
      OP_MUL:  result = A * B;
      OP_DIV:  result = quotient;
      OP_SHL:  result = {A[WIDTH-2:0], 1'b0};
      OP_SHR:  result = {1'b0, A[WIDTH-1:1]};
      OP_ROL:  result = {A[WIDTH-2:0], A[WIDTH-1]};
      OP_ROR:  result = {A[0], A[WIDTH-1:1]};
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_XOR:  result = A ^ B;
      OP_NOR:  result = ~(A | B);
      OP_NAND: result = ~(A & B);
      OP_XNOR: result = ~(A ^ B);
      OP_GT:   result = {{(WIDTH-1){1'b0}}, (A > B)};
      OP_EQ:   result = {{(WIDTH-1){1'b0}}, (A == B)};
      default: result = '0;
    endcase
  end

  // Output registers; a low rst_n discards the operation at this edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ALU_Out  <= '0;
      CarryOut <= 1'b0;
    end else begin
      ALU_Out  <= result;
      CarryOut <= sum_full[WIDTH];
    end
  end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed vectors plus randomized operations. Expected
// values are computed with integer arithmetic and queued, then compared
// with the registered outputs one cycle later.
module tb_alu;
  localparam int W   = 8;
  localparam int MOD = 1 << W;

  // Clock and reset
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   sel = '0;
  logic [W-1:0] alu_out;
  logic         carry_out;

  always #5 clk = ~clk;

  alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (a),
    .B        (b),
    .ALU_Sel  (sel),
    .ALU_Out  (alu_out),
    .CarryOut (carry_out)
  );

  // Scoreboard state: each entry is {carry, result}
  logic [W:0] exp_q[$];
  logic [W:0] last_exp = '0;
  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got carry=%b out=%h, expected carry=%b out=%h",
                  tag, obs[W], obs[W-1:0], exp[W], exp[W-1:0]);
  endtask

  // Reference model: plain integer arithmetic, bitwise ops bit by bit
  function automatic logic [W:0] ref_model(input logic [3:0] s, input int av, input int bv);
    int r;
    int ai;
    int bi;
    int o;
    logic carry;
    r = 0;
    case (s)
      4'd0:  r = (av + bv) % MOD;
      4'd1:  r = (av - bv + MOD) % MOD;
      4'd2:  r = (av * bv) % MOD;
      4'd3:  r = (bv == 0) ? MOD - 1 : av / bv;
      4'd4:  r = (av * 2) % MOD;
      4'd5:  r = av / 2;
      4'd6:  r = (av * 2) % MOD + av / (MOD / 2);
      4'd7:  r = av / 2 + (av % 2) * (MOD / 2);
      4'd14: r = (av > bv) ? 1 : 0;
      4'd15: r = (av == bv) ? 1 : 0;
      default: begin
        for (int i = 0; i < W; i++) begin
          ai = (av >> i) & 1;
          bi = (bv >> i) & 1;
          case (s)
            4'd8:    o = ai & bi;
            4'd9:    o = ai | bi;
            4'd10:   o = (ai != bi) ? 1 : 0;
            4'd11:   o = (ai | bi) ? 0 : 1;
            4'd12:   o = (ai & bi) ? 0 : 1;
            default: o = (ai == bi) ? 1 : 0;
          endcase
          r = r + o * (1 << i);
        end
      end
    endcase
    carry = ((av + bv) >= MOD);
    return {carry, r[W-1:0]};
  endfunction

  // Driver: present one operation, let the edge capture it, then compare
  task automatic run_op(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic r_n, input string tag);
    @(negedge clk);
    sel   = s;
    a     = x;
    b     = y;
    rst_n = r_n;
    exp_q.push_back(r_n ? ref_model(s, int'(x), int'(y)) : '0);
    @(posedge clk);
    #1;
    last_exp = exp_q.pop_front();
    check(tag, {carry_out, alu_out}, last_exp);
  endtask

  // Disturb inputs and rst_n between edges; outputs must not move
  task automatic hold_check(input string tag);
    #1;
    a     = W'($urandom);
    b     = W'($urandom);
    sel   = 4'($urandom);
    rst_n = 1'b0;
    #2;
    check(tag, {carry_out, alu_out}, last_exp);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held: outputs stay zero whatever is presented
    run_op(4'b0000, 8'hFF, 8'h01, 1'b0, "reset_0");
    run_op(4'b1111, 8'h7E, 8'h7E, 1'b0, "reset_1");

    // Directed vectors
    run_op(4'b1010, 8'hA5, 8'h0F, 1'b1, "xor_a5_0f");
    run_op(4'b0000, 8'hFF, 8'h01, 1'b1, "add_ovf");
    run_op(4'b0001, 8'h00, 8'h01, 1'b1, "sub_wrap");
    run_op(4'b0011, 8'h64, 8'h00, 1'b1, "div_zero");
    run_op(4'b0011, 8'h64, 8'h05, 1'b1, "div_64_05");
    run_op(4'b0010, 8'h10, 8'h11, 1'b1, "mul_10_11");
    run_op(4'b0100, 8'h81, 8'h00, 1'b1, "shl_81");
    run_op(4'b0101, 8'h81, 8'h00, 1'b1, "shr_81");
    run_op(4'b0110, 8'h81, 8'h00, 1'b1, "rol_81");
    run_op(4'b0111, 8'h81, 8'h00, 1'b1, "ror_81");
    run_op(4'b1110, 8'h05, 8'h03, 1'b1, "gt_05_03");
    run_op(4'b1110, 8'h03, 8'h05, 1'b1, "gt_03_05");
    run_op(4'b1111, 8'h7E, 8'h7E, 1'b1, "eq_7e");
    hold_check("hold_mid_cycle");

    // Every op at the operand extremes
    for (int s = 0; s < 16; s++) begin
      run_op(4'(s), 8'hFF, 8'hFF, 1'b1, "corner_ff");
      run_op(4'(s), 8'h00, 8'h00, 1'b1, "corner_00");
    end

    // Mid-stream reset discards the pending op; release resumes at once
    run_op(4'b0000, 8'hFF, 8'h01, 1'b1, "rst_pre_add");
    run_op(4'b0000, 8'hFF, 8'h01, 1'b0, "rst_mid");
    run_op(4'b1010, 8'hA5, 8'h0F, 1'b1, "rst_release");

    // XOR sweep
    for (int i = 0; i < 40; i++)
      run_op(4'b1010, W'($urandom), W'($urandom), 1'b1, "xor_sweep");

    // Random ops with occasional reset and mid-cycle disturbance
    for (int i = 0; i < 300; i++) begin
      run_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom_range(0, 3) == 0 ? 0 : $urandom),
             ($urandom_range(0, 15) != 0), "random_op");
      if ($urandom_range(0, 9) == 0) hold_check("random_hold");
    end

    if (exp_q.size() != 0) check("queue_empty", W+1'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits; all values below are stated for WIDTH=8.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
REQ-004 Port: A  input  WIDTH  operand A, unsigned.
REQ-005 Port: B  input  WIDTH  operand B, unsigned.
REQ-006 Port: ALU_Sel  input  4  operation select.
REQ-007 Port: ALU_Out  output  WIDTH  registered result.
REQ-008 Port: CarryOut  output  1  registered carry.
REQ-009 The block SHALL use one clock (clk) and a synchronous active-low reset (rst_n); no other clocks, resets or handshake signals.

Function
REQ-010 On each rising clk edge with rst_n=1, ALU_Out SHALL load the result of ALU_Sel applied to the current A and B; latency is exactly 1 cycle, throughput 1 operation per cycle.
REQ-011 0000 ADD: A+B, low WIDTH bits (wraps).
REQ-012 0001 SUB: A-B modulo 2^WIDTH (wraps; 00-01 = FF).
REQ-013 0010 MUL: low WIDTH bits of A*B.
REQ-014 0011 DIV: floor(A/B); B=0 SHALL yield all-ones (FF).
REQ-015 0100 SHL: A shifted left by 1, LSB filled 0; 0101 SHR: A shifted right by 1 logical, MSB filled 0.
REQ-016 0110 ROL: A rotated left by 1; 0111 ROR: A rotated right by 1.
REQ-017 1000 AND, 1001 OR, 1010 XOR, 1011 NOR, 1100 NAND, 1101 XNOR: bitwise on A and B.
REQ-018 1110 GT: 1 if A>B (unsigned), else 0 (zero-extended to WIDTH).
REQ-019 1111 EQ: 1 if A==B, else 0 (zero-extended to WIDTH).
REQ-020 CarryOut SHALL load bit WIDTH of the (WIDTH+1)-bit sum A+B on every operation, independent of ALU_Sel.
REQ-021 Result computation SHALL be purely combinational from the A, B and ALU_Sel values sampled at the same edge; no internal state other than the two output registers.
REQ-022 Operand or select changes between edges SHALL NOT affect the outputs until the next rising edge.

Reset
REQ-023 When rst_n=0 at a rising clk edge, ALU_Out SHALL become 0 and CarryOut SHALL become 0, overriding any operation.
REQ-024 Outputs SHALL hold 0 on every edge while rst_n=0; the first operation is captured on the first edge with rst_n=1.
REQ-025 Asserting rst_n=0 mid-stream SHALL discard the operation presented at that edge; no pending result survives reset.
REQ-026 rst_n SHALL have no asynchronous effect; changing rst_n between edges leaves outputs unchanged.

Verification
REQ-027 XOR: rst_n=1, ALU_Sel=1010, A=A5, B=0F -> next cycle ALU_Out=AA, CarryOut=0; sweep 1010 with random A/B against A^B.
REQ-028 ADD overflow: ALU_Sel=0000, A=FF, B=01 -> ALU_Out=00, CarryOut=1; SUB A=00, B=01 -> ALU_Out=FF, CarryOut=0.
REQ-029 DIV/MUL: ALU_Sel=0011, A=64, B=00 -> ALU_Out=FF; ALU_Sel=0011, A=64, B=05 -> 14; ALU_Sel=0010, A=10, B=11 -> 10.
REQ-030 Shift/rotate: A=81, ALU_Sel 0100 -> 02, 0101 -> 40, 0110 -> 03, 0111 -> C0.
REQ-031 Compare: ALU_Sel=1110, A=05, B=03 -> 01, A=03, B=05 -> 00; ALU_Sel=1111, A=B=7E -> 01.
REQ-032 Reset: run ADD A=FF, B=01, then drive rst_n=0 for one edge -> ALU_Out=00, CarryOut=0 on that edge; release -> next edge shows the new operation's result.
